// File: rtl/retire_ctrl.sv
// Retirement sequencer: gates the commit stage and runs the trap/watchdog
// flush-redirect handshake plus debug halt/resume around in-order retirement.
module retire_ctrl #(
  parameter int          PC_W       = 32,
  parameter int          WDOG_LIMIT = 1024,
  parameter logic [31:0] WDOG_CAUSE = 32'h0000_0018
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rob_head_valid,
  input  logic            rob_head_done,
  input  logic            rob_head_has_trap,
  input  logic [31:0]     rob_head_trap_cause,
  input  logic [PC_W-1:0] rob_head_pc,
  input  logic            commit_valid,
  input  logic [PC_W-1:0] trap_vec_base,
  input  logic            halt_req,
  input  logic            resume_req,
  input  logic            flush_ack,
  input  logic            redirect_ready,
  output logic            retire_en,
  output logic            flush_req,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] trap_epc,
  output logic [31:0]     trap_cause,
  output logic            halted,
  output logic [1:0]      state,
  output logic [31:0]     trap_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_t;

  // The counter only needs to reach WDOG_LIMIT-1; the trip happens on the next stall.
  localparam int              CNT_W   = $clog2(WDOG_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_LIMIT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall;
  logic             trap_hit;
  logic             wdog_hit;

  assign stall    = rob_head_valid && !rob_head_done;
  assign trap_hit = commit_valid && rob_head_has_trap;
  assign wdog_hit = stall && (stall_cnt == CNT_MAX);

  always_comb begin
    state_d        = state_q;
    retire_en      = 1'b0;
    flush_req      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halted         = 1'b0;
    case (state_q)
      RUN: begin
        retire_en = !halt_req;
        if (trap_hit || wdog_hit) state_d = FLUSH;
        else if (halt_req)        state_d = HALT;
      end
      FLUSH: begin
        flush_req = 1'b1;
        if (flush_ack) state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = {trap_vec_base[PC_W-1:2], 2'b00};
        if (redirect_ready) state_d = RUN;
      end
      HALT: begin
        halted = 1'b1;
        if (resume_req && !halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      // Counting is only meaningful while staying in RUN; any exit or progress clears it.
      if (state_q == RUN && state_d == RUN && stall) stall_cnt <= stall_cnt + 1'b1;
      else                                          stall_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_epc   <= '0;
      trap_cause <= '0;
      trap_count <= '0;
    end else if (state_q == RUN) begin
      if (trap_hit) begin
        trap_epc   <= rob_head_pc;
        trap_cause <= rob_head_trap_cause;
        trap_count <= trap_count + 32'd1;
      end else if (wdog_hit) begin
        trap_epc   <= rob_head_pc;
        trap_cause <= WDOG_CAUSE;
        trap_count <= trap_count + 32'd1;
      end
    end
  end

`ifndef SYNTHESIS
  // Commit may only pop the head while retirement is live.
  commit_only_in_run: assert property (@(posedge clk) disable iff (rst)
    commit_valid |-> (state_q == RUN));
`endif

endmodule

// File: doc/retire_ctrl.md
Name: retire_ctrl

Overview:
- Sequencer that drives the commit stage's `retire_en` and owns the trap/halt flow around in-order retirement.
- Watches the ROB head and the commit handshake. On a trap or watchdog event it stops retirement, captures EPC and cause, then runs a flush and redirect handshake with the front end.
- Also services debug halt/resume.
- Sits between the ROB/commit stage and the fetch/flush logic of the Z480 P7 core.

Parameters:
- PC_W, 32, program-counter width.
- WDOG_LIMIT, 1024, consecutive head-stall cycles that trip the watchdog (must be ≥2).
- WDOG_CAUSE, 32'h0000_0018, cause code reported on a watchdog trip.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- rob_head_valid  in  1  ROB head entry valid.
- rob_head_done  in  1  ROB head entry complete.
- rob_head_has_trap  in  1  head entry carries a trap.
- rob_head_trap_cause  in  32  head trap cause.
- rob_head_pc  in  PC_W  head entry PC.
- commit_valid  in  1  commit stage retired/popped the head this cycle.
- trap_vec_base  in  PC_W  trap vector base; bits [1:0] ignored.
- halt_req  in  1  debug halt request (level).
- resume_req  in  1  debug resume request (level).
- flush_ack  in  1  pipeline flush complete.
- redirect_ready  in  1  front end accepts redirect.
- retire_en  out  1  enable to the commit stage.
- flush_req  out  1  pipeline flush request (level).
- redirect_valid  out  1  redirect request.
- redirect_pc  out  PC_W  redirect target.
- trap_epc  out  PC_W  captured exception PC.
- trap_cause  out  32  captured cause.
- halted  out  1  core is in debug halt.
- state  out  2  encoded FSM state.
- trap_count  out  32  traps taken, including watchdog trips.

Behaviour:
- FSM states: RUN=0, FLUSH=1, REDIRECT=2, HALT=3.
- Reset values: state=RUN; all outputs 0 except retire_en; counters 0.
- retire_en = (state==RUN) and no halt_req; combinational from state and halt_req. It is therefore 1 out of reset when halt_req=0.
- RUN, trap:
  - Trigger: commit_valid && rob_head_has_trap.
  - Same edge: trap_epc←rob_head_pc, trap_cause←rob_head_trap_cause, trap_count+1 (wraps at 2^32), next=FLUSH.
- RUN, watchdog:
  - Stall counter increments each RUN cycle with rob_head_valid && !rob_head_done.
  - Cleared to 0 on any other RUN cycle and on leaving RUN.
  - When the counter equals WDOG_LIMIT-1 and the stall condition holds: trap_epc←rob_head_pc, trap_cause←WDOG_CAUSE, trap_count+1, next=FLUSH.
  - The trip therefore occurs on the WDOG_LIMIT-th consecutive stall cycle.
- RUN, halt: halt_req=1 and no trap/watchdog this cycle → next=HALT.
- RUN priority on the same cycle: trap > watchdog > halt.
  - Watchdog cannot coincide with commit_valid, because the head is not done.
- FLUSH:
  - flush_req=1 and retire_en=0 while in FLUSH.
  - On flush_ack → next=REDIRECT.
  - flush_ack is ignored outside FLUSH.
- REDIRECT:
  - redirect_valid=1 and redirect_pc={trap_vec_base[PC_W-1:2],2'b00} while in REDIRECT.
  - redirect_pc is held stable until redirect_ready.
  - On redirect_ready → next=RUN.
  - halt_req is not sampled in FLUSH or REDIRECT; it takes effect in the first RUN cycle after them. retire_en stays 0 that cycle if halt_req is still asserted.
- HALT:
  - halted=1 and retire_en=0.
  - On resume_req && !halt_req → next=RUN.
  - If resume_req and halt_req are both 1, stay in HALT.
  - The watchdog does not count in HALT.
- trap_epc and trap_cause hold their values until the next capture.
- commit_valid outside RUN is a protocol violation; ignore it. Include a simulation-only assertion for it.
- rst asserted mid-sequence (e.g. in FLUSH) aborts asynchronously to RUN with all outputs at reset values; no redirect is issued.

Test Plan:
- Reset, then head valid+done with no traps for 10 cycles and commit_valid each cycle → retire_en=1 throughout, state=0, trap_count=0.
- commit_valid with has_trap, cause=32'h2, pc=32'h0000_1234, trap_vec_base=32'h0000_8003:
  - retire_en=0 next cycle and flush_req=1 until flush_ack.
  - Then redirect_valid=1, redirect_pc=32'h0000_8000 held until redirect_ready.
  - Then RUN; trap_epc=32'h1234, trap_cause=2, trap_count=1.
- WDOG_LIMIT=4, head valid and !done held:
  - On the 4th stall cycle state→FLUSH with trap_cause=32'h18.
  - Repeat with done asserted on the 3rd cycle → no trip and the counter resets.
- halt_req in RUN → halted=1 next cycle, retire_en=0.
  - resume_req with halt_req=1 → stays in HALT.
  - Drop halt_req → RUN.
- Trap commit and halt_req in the same cycle → FLUSH taken.
  - halt_req still high after redirect → HALT on the cycle after returning to RUN.
- rst pulsed while in REDIRECT with redirect_ready=0 → state=RUN and redirect_valid=0 immediately; trap_count=0.
